fifo_to_packet: RTL and testbench
=================================

# fifo_to_packet

Read-side counterpart to the packet writer. It drains fixed-size words from a synchronous FIFO and reassembles them into one wide packet, lowest word first. It then presents the packet on a valid/ready interface. It sits between the RAM FIFO read port and any consumer that needs whole packets, for example a command decoder or a UART/SPI framer. A partial packet that stalls past a timeout is discarded and flagged.

## Interface
- pPacketSize, 4, packet size in bytes; must be an integer multiple of pFifoDataWidth.
- pFifoDataWidth, 1, FIFO word width in bytes (1 or 2).
- pTimeout, 256, idle cycles allowed mid-packet before discard; 0 disables the timeout.
- Derived values: N = pPacketSize/pFifoDataWidth words per packet; W = 8*pFifoDataWidth; P = 8*pPacketSize.

Ports:
- iClk  in  1  system clock; the only clock.
- iRst  in  1  reset; synchronous, active-high.
- oRdEn  out  1  FIFO read strobe.
- iRdEmpty  in  1  FIFO empty flag.
- iRdData  in  W  FIFO read data, valid the cycle after oRdEn.
- oPacketData  out  P  assembled packet.
- oPacketValid  out  1  packet complete and stable.
- iPacketReady  in  1  consumer accepts the packet.
- oErr  out  1  one-cycle pulse when a partial packet is discarded on timeout.

## Operation
- States:
  - IDLE: no words captured.
  - FILL: 1 to N words issued or captured.
  - HOLD: packet complete.
  - ERROR: discard.
- oRdEn = (state is IDLE or FILL) && !iRdEmpty && rIssued < N. It is combinational from registered state and iRdEmpty. Reads never occur in HOLD or ERROR.
- rIssued increments on every oRdEn. rRdValid <= oRdEn.
- When rRdValid=1, iRdData is written to oPacketData[rCap*W +: W], then rCap increments. Word 0 lands in bits [W-1:0].
- State transitions:
  - IDLE→FILL on the first oRdEn.
  - FILL→HOLD on the cycle of the N-th capture.
  - HOLD→IDLE when oPacketValid && iPacketReady. rIssued and rCap clear at that point.
- oPacketValid=1 exactly in HOLD. oPacketData is stable throughout HOLD. Its value outside HOLD carries no meaning.
- Timeout counter:
  - Runs only in FILL.
  - Increments on cycles with oRdEn=0 and rRdValid=0.
  - Clears on any read or capture.
  - When it reaches pTimeout-1 and the next cycle also idles, the state goes to ERROR.
- ERROR lasts one cycle with oErr=1. In it the counters and oPacketData clear to 0, then the state returns to IDLE. The words already read are lost; the FIFO is not rewound.
- Width rules:
  - rIssued and rCap are $clog2(N+1) bits.
  - The timeout counter is $clog2(pTimeout+1) bits.
  - There is no wrap: rIssued saturates at N by the read gating.

## Timing
- Reset values: oRdEn=0 while iRst=1, oPacketValid=0, oErr=0, oPacketData=0. State is IDLE with all counters 0.
- Reset mid-packet discards the partial packet silently; no oErr.
- Latency with the FIFO continuously non-empty:
  - First oRdEn at cycle t.
  - Reads back-to-back at t..t+N-1.
  - Captures at t+1..t+N.
  - oPacketValid=1 from t+N+1.
- When iRdEmpty goes high mid-packet, reads pause. The in-flight word is still captured the next cycle. Reads resume the cycle iRdEmpty falls.
- iPacketReady may be held high in advance. The minimum HOLD is then 1 cycle, and the next read may issue in the IDLE cycle after the handshake. Sustained throughput is one packet per N+2 cycles.
- A capture and a timeout expiry in the same cycle: the capture wins and the counter clears.
- Timeout cannot trigger while a read is in flight.
- pTimeout=0: FILL waits indefinitely.

## Structure
- State encodings live in a shared include file used by both the writer and this reader: IDLE=0, FILL=1, HOLD=2, ERROR=3, 2 bits.
- The derived-width helper also goes in that shared include file.
- Single module, no sub-modules. The timeout counter is a small always block inside this module.

## Test plan
- pPacketSize=4, pFifoDataWidth=1, FIFO preloaded with 0x11,0x22,0x33,0x44, iPacketReady=1 -> oRdEn high 4 consecutive cycles; oPacketValid for 1 cycle at t+5 with oPacketData=0x44332211.
- pFifoDataWidth=2, pPacketSize=4, words 0xBEEF,0xDEAD -> oPacketData=0xDEADBEEF.
- iPacketReady=0 for 10 cycles with 8 more words queued -> oPacketValid and data held constant, oRdEn=0 throughout. On ready, the next packet 0x88776655 follows.
- FIFO empties after 2 of 4 words, then refills 50 cycles later (pTimeout=256) -> packet assembles correctly, no oErr.
- 2 of 4 words, then empty for 300 cycles with pTimeout=8 -> one oErr pulse about 9 idle cycles after the last capture, then oPacketData=0. A following full packet assembles cleanly.
- iRst asserted after 3 of 4 words -> all outputs 0 the next cycle; subsequent words start a new packet at word 0.

Source files
------------

// File: rtl/fifo_to_packet_pkg.sv
// Shared definitions for the FIFO packet writer/reader pair: FSM encoding and
// the counter-width helper.
package fifo_to_packet_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        HOLD  = 2'd2,
        ERROR = 2'd3
    } state_t;

    // Bits needed to count 0..maxVal, never less than one bit.
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/fifo_to_packet.sv
// Drains fixed-size words from a synchronous FIFO read port and assembles them,
// lowest word first, into one wide packet offered on a valid/ready interface.
module fifo_to_packet
    import fifo_to_packet_pkg::*;
#(
    parameter int pPacketSize    = 4,
    parameter int pFifoDataWidth = 1,
    parameter int pTimeout       = 256
) (
    input  logic                        iClk,
    input  logic                        iRst,
    output logic                        oRdEn,
    input  logic                        iRdEmpty,
    input  logic [8*pFifoDataWidth-1:0] iRdData,
    output logic [8*pPacketSize-1:0]    oPacketData,
    output logic                        oPacketValid,
    input  logic                        iPacketReady,
    output logic                        oErr,
    output logic [1:0]                  oState
);

    localparam int N  = pPacketSize / pFifoDataWidth;
    localparam int W  = 8 * pFifoDataWidth;
    localparam int P  = 8 * pPacketSize;
    localparam int CW = cntWidth(N);
    localparam int TW = cntWidth(pTimeout);

    state_t        state;
    state_t        stateNext;
    logic [CW-1:0] rIssued;
    logic [CW-1:0] rCap;
    logic          rRdValid;
    logic [TW-1:0] rIdleCnt;
    logic [P-1:0]  rPacketData;

    logic          rdEn;
    logic          lastCap;
    logic          idleCycle;
    logic          timeoutHit;
    logic          handshake;

    // Handshake: the packet transfers on any cycle with oPacketValid && iPacketReady;
    // oPacketValid never drops and oPacketData never changes until that transfer.
    always_comb begin
        rdEn       = ((state == IDLE) || (state == FILL)) && !iRdEmpty
                     && (rIssued < CW'(N)) && !iRst;
        lastCap    = rRdValid && (rCap == CW'(N - 1));
        idleCycle  = (state == FILL) && !rdEn && !rRdValid;
        timeoutHit = (pTimeout != 0) && idleCycle && (rIdleCnt == TW'(pTimeout - 1));
        handshake  = (state == HOLD) && iPacketReady;
        stateNext  = state;
        unique case (state)
            IDLE:    if (rdEn) stateNext = FILL;
            FILL: begin
                if (lastCap)         stateNext = HOLD;
                else if (timeoutHit) stateNext = ERROR;
            end
            HOLD:    if (handshake) stateNext = IDLE;
            ERROR:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state       <= IDLE;
            rIssued     <= '0;
            rCap        <= '0;
            rRdValid    <= 1'b0;
            rPacketData <= '0;
        end else begin
            state    <= stateNext;
            rRdValid <= rdEn;
            if (state == ERROR) begin
                // Words already pulled from the FIFO are dropped, not rewound.
                rIssued     <= '0;
                rCap        <= '0;
                rPacketData <= '0;
            end else if (handshake) begin
                rIssued <= '0;
                rCap    <= '0;
            end else begin
                if (rdEn) begin
                    rIssued <= rIssued + CW'(1);
                end
                if (rRdValid) begin
                    rPacketData[int'(rCap)*W +: W] <= iRdData;
                    rCap                           <= rCap + CW'(1);
                end
            end
        end
    end

    // Counts FILL cycles with neither a read issued nor a word landing.
    always_ff @(posedge iClk) begin
        if (iRst || !idleCycle || timeoutHit) begin
            rIdleCnt <= '0;
        end else begin
            rIdleCnt <= rIdleCnt + TW'(1);
        end
    end

    assign oRdEn        = rdEn;
    assign oPacketData  = rPacketData;
    assign oPacketValid = (state == HOLD);
    assign oErr         = (state == ERROR);
    assign oState       = state;

endmodule

// File: tb/tb_fifo_to_packet.sv
// Bench for fifo_to_packet: lane 0 uses byte words with a short timeout, lane 1
// uses 16-bit words with the default timeout; both share clock and reset.
module tb_fifo_to_packet;

    localparam int TO0 = 8;
    localparam int TO1 = 256;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  empty;
    logic [1:0]  ready;
    logic [7:0]  rdData0;
    logic [15:0] rdData1;
    wire  [1:0]  rdEn;
    wire  [1:0]  valid;
    wire  [1:0]  err;
    wire  [31:0] pkt0;
    wire  [31:0] pkt1;
    wire  [1:0]  st0;
    wire  [1:0]  st1;

    fifo_to_packet #(.pPacketSize(4), .pFifoDataWidth(1), .pTimeout(TO0)) dut0 (
        .iClk(clk), .iRst(rst), .oRdEn(rdEn[0]), .iRdEmpty(empty[0]), .iRdData(rdData0),
        .oPacketData(pkt0), .oPacketValid(valid[0]), .iPacketReady(ready[0]),
        .oErr(err[0]), .oState(st0)
    );

    fifo_to_packet #(.pPacketSize(4), .pFifoDataWidth(2), .pTimeout(TO1)) dut1 (
        .iClk(clk), .iRst(rst), .oRdEn(rdEn[1]), .iRdEmpty(empty[1]), .iRdData(rdData1),
        .oPacketData(pkt1), .oPacketValid(valid[1]), .iPacketReady(ready[1]),
        .oErr(err[1]), .oState(st1)
    );

    int          nAssert;
    int          nFail;
    int          cyc;
    logic [15:0] fifoMem [2][0:1023];
    int          head [2];
    int          tail [2];
    logic [15:0] nextWord [2];
    int          partCnt [2];
    logic [31:0] partVal [2];
    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];
    logic        rstN;
    logic [1:0]  readyN;
    logic [1:0]  allowErr;
    int          gap [2];
    logic [15:0] rw [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nAssert++;
        assert (obs === expv) else begin
            nFail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h at cycle %0d", tag, obs, expv, cyc);
        end
    endtask

    function automatic int nWords(input int ln);
        return (ln == 0) ? 4 : 2;
    endfunction

    function automatic int wordBits(input int ln);
        return (ln == 0) ? 8 : 16;
    endfunction

    function automatic logic [31:0] pktOf(input int ln);
        return (ln == 0) ? pkt0 : pkt1;
    endfunction

    function automatic int expSize(input int ln);
        return (ln == 0) ? exp0_q.size() : exp1_q.size();
    endfunction

    function automatic logic [31:0] expPop(input int ln);
        if (ln == 0) return exp0_q.pop_front();
        return exp1_q.pop_front();
    endfunction

    task automatic pushWord(input int ln, input logic [15:0] w);
        fifoMem[ln][tail[ln] % 1024] = (ln == 0) ? {8'h00, w[7:0]} : w;
        tail[ln]++;
    endtask

    // One clock cycle: drive inputs at the falling edge, sample, then update the
    // FIFO contents and the packet scoreboard from what the DUT did.
    task automatic step();
        logic [15:0] w;
        @(negedge clk);
        rst     = rstN;
        ready   = readyN;
        rdData0 = nextWord[0][7:0];
        rdData1 = nextWord[1];
        for (int ln = 0; ln < 2; ln++) empty[ln] = (head[ln] == tail[ln]);
        #1;
        for (int ln = 0; ln < 2; ln++) begin
            if (rst) chk("rdEn_in_reset", 32'(rdEn[ln]), 32'd0);
            if (valid[ln]) chk("rdEn_in_hold", 32'(rdEn[ln]), 32'd0);
            if (!allowErr[ln]) chk("no_err", 32'(err[ln]), 32'd0);
            if (valid[ln] && ready[ln] && !rst) begin
                if (expSize(ln) == 0) chk("unexpected_packet", 32'(valid[ln]), 32'd0);
                else chk("packet_data", pktOf(ln), expPop(ln));
            end
            if (err[ln]) begin
                partCnt[ln] = 0;
                partVal[ln] = '0;
            end
            if (rst) begin
                partCnt[ln] = 0;
                partVal[ln] = '0;
                if (ln == 0) exp0_q.delete();
                else exp1_q.delete();
            end else if (rdEn[ln]) begin
                if (head[ln] == tail[ln]) begin
                    chk("read_while_empty", 32'(rdEn[ln]), 32'd0);
                end else begin
                    w = fifoMem[ln][head[ln] % 1024];
                    head[ln]++;
                    nextWord[ln] = w;
                    partVal[ln] = partVal[ln] | (32'(w) << (partCnt[ln] * wordBits(ln)));
                    partCnt[ln]++;
                    if (partCnt[ln] == nWords(ln)) begin
                        if (ln == 0) exp0_q.push_back(partVal[ln]);
                        else exp1_q.push_back(partVal[ln]);
                        partCnt[ln] = 0;
                        partVal[ln] = '0;
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic waitValid(input int ln, input int budget, input string tag);
        int i;
        i = 0;
        do begin
            step();
            i++;
        end while (!valid[ln] && i < budget);
        chk(tag, 32'(valid[ln]), 32'd1);
    endtask

    initial begin
        nAssert = 0; nFail = 0; cyc = 0;
        rstN = 1'b1; readyN = 2'b00; allowErr = 2'b00;
        rst = 1'b1; ready = 2'b00; empty = 2'b11; rdData0 = '0; rdData1 = '0;
        for (int ln = 0; ln < 2; ln++) begin
            head[ln] = 0; tail[ln] = 0; nextWord[ln] = '0;
            partCnt[ln] = 0; partVal[ln] = '0; gap[ln] = 0;
        end

        // Reset values, with data already waiting in both FIFOs.
        step();
        pushWord(0, 16'h11); pushWord(0, 16'h22); pushWord(0, 16'h33); pushWord(0, 16'h44);
        pushWord(1, 16'hBEEF); pushWord(1, 16'hDEAD);
        step();
        chk("reset_valid0", 32'(valid[0]), 32'd0);
        chk("reset_valid1", 32'(valid[1]), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_pkt0", pkt0, 32'd0);
        chk("reset_pkt1", pkt1, 32'd0);
        chk("reset_state0", 32'(st0), 32'd0);
        chk("reset_state1", 32'(st1), 32'd0);

        // Back-to-back latency with ready held high in advance.
        readyN = 2'b11;
        rstN   = 1'b0;
        for (int s = 0; s < 8; s++) begin
            step();
            chk("lat_rd0", 32'(rdEn[0]), 32'(s < 4));
            chk("lat_valid0", 32'(valid[0]), 32'(s == 5));
            chk("lat_rd1", 32'(rdEn[1]), 32'(s < 2));
            chk("lat_valid1", 32'(valid[1]), 32'(s == 3));
            if (s == 5) chk("lat_data0", pkt0, 32'h44332211);
            if (s == 3) chk("lat_data1", pkt1, 32'hDEADBEEF);
        end

        // Consumer backpressure with two packets queued behind.
        readyN[0] = 1'b0;
        for (int i = 0; i < 8; i++) pushWord(0, 16'(8'h55 + 8'(i * 8'h11)));
        waitValid(0, 12, "bp_wait");
        chk("bp_data", pkt0, 32'h88776655);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", 32'(valid[0]), 32'd1);
            chk("bp_data_hold", pkt0, 32'h88776655);
            chk("bp_rdEn", 32'(rdEn[0]), 32'd0);
        end
        readyN[0] = 1'b1;
        step();
        waitValid(0, 12, "bp_next_wait");
        chk("bp_next_data", pkt0, 32'hCCBBAA99);
        step();

        // Mid-packet FIFO underrun shorter than the timeout on both lanes.
        pushWord(1, 16'h1234);
        pushWord(0, 16'hA1); pushWord(0, 16'hA2);
        for (int i = 0; i < 51; i++) begin
            if (i == 5) begin
                pushWord(0, 16'hA3); pushWord(0, 16'hA4);
            end
            step();
        end
        chk("short_stall_delivered", 32'(exp0_q.size()), 32'd0);
        chk("stall_no_valid", 32'(valid[1]), 32'd0);
        pushWord(1, 16'h5678);
        waitValid(1, 6, "stall_wait");
        chk("stall_data", pkt1, 32'h56781234);
        step();

        // Timeout: two words land, then the FIFO stays empty.
        allowErr[0] = 1'b1;
        pushWord(0, 16'h01); pushWord(0, 16'h02);
        for (int s = 0; s < 20; s++) begin
            step();
            // last read at s=1, capture at s=2, TO0 idle cycles, then the error cycle
            chk("to_err", 32'(err[0]), 32'(s == TO0 + 3));
            chk("to_no_valid", 32'(valid[0]), 32'd0);
        end
        chk("to_cleared_pkt", pkt0, 32'd0);
        allowErr[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rw[i] = 16'($urandom_range(0, 255));
            pushWord(0, rw[i]);
        end
        waitValid(0, 10, "to_recover_wait");
        chk("to_recover_data", pkt0, {rw[3][7:0], rw[2][7:0], rw[1][7:0], rw[0][7:0]});
        step();

        // Reset after three words have been read.
        pushWord(0, 16'h31); pushWord(0, 16'h32); pushWord(0, 16'h33);
        step(); step(); step();
        rstN = 1'b1;
        step();
        rstN = 1'b0;
        step();
        chk("rst_mid_valid", 32'(valid[0]), 32'd0);
        chk("rst_mid_err", 32'(err[0]), 32'd0);
        chk("rst_mid_pkt", pkt0, 32'd0);
        chk("rst_mid_rdEn", 32'(rdEn[0]), 32'd0);
        pushWord(0, 16'h41); pushWord(0, 16'h42); pushWord(0, 16'h43); pushWord(0, 16'h44);
        waitValid(0, 10, "rst_new_wait");
        chk("rst_new_data", pkt0, 32'h44434241);
        step();

        // Random traffic and ready; FIFO gaps kept short of the lane 0 timeout.
        for (int c = 0; c < 300; c++) begin
            readyN = 2'($urandom_range(0, 3));
            for (int ln = 0; ln < 2; ln++) begin
                if ($urandom_range(0, 1) == 1 || gap[ln] >= 3) begin
                    pushWord(ln, 16'($urandom_range(0, 65535)));
                    gap[ln] = 0;
                end else begin
                    gap[ln]++;
                end
            end
            step();
        end

        // Drain everything still queued; a trailing lane 0 fragment may time out.
        readyN   = 2'b11;
        allowErr = 2'b11;
        for (int i = 0; i < 600 && (head[0] != tail[0] || head[1] != tail[1]
                                    || exp0_q.size() != 0 || exp1_q.size() != 0); i++) begin
            step();
        end
        chk("drain_exp0", 32'(exp0_q.size()), 32'd0);
        chk("drain_exp1", 32'(exp1_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
